// File: rtl/vector_pkg.sv
// ---------------------------------------------------------------------------
// vector_pkg
// Shared types and constants for the vector display-list path.
//   - state_t      : sequencer states (PARK exists only with VEC_PARK_RETURN_EN)
//   - EOL_BIT, POS_BIT, LINE_BIT, X_LSB, Y_LSB : list-word field positions
//   - entry_t      : a decoded list word
//   - decode_word  : splits a raw list word into an entry_t
// Optional feature macro: VEC_PARK_RETURN_EN adds the PARK state.
// ---------------------------------------------------------------------------
package vector_pkg;

    localparam int VEC_OUT_WIDTH  = 8;
    localparam int VEC_ADDR_WIDTH = 8;
    localparam int VEC_WORD_WIDTH = 2 * VEC_OUT_WIDTH + 3;

    // Word layout, MSB first: eol, pos, line, x, y.
    localparam int EOL_BIT  = VEC_WORD_WIDTH - 1;
    localparam int POS_BIT  = VEC_WORD_WIDTH - 2;
    localparam int LINE_BIT = VEC_WORD_WIDTH - 3;
    localparam int X_LSB    = VEC_OUT_WIDTH;
    localparam int Y_LSB    = 0;

    typedef enum logic [2:0] {
        HOLD,
        RD,
        LOAD,
        PRESENT,
        DRAIN
`ifdef VEC_PARK_RETURN_EN
        , PARK
`endif
    } state_t;

    typedef struct packed {
        logic                     eol;
        logic                     pos;
        logic                     line;
        logic [VEC_OUT_WIDTH-1:0] x;
        logic [VEC_OUT_WIDTH-1:0] y;
    } entry_t;

    function automatic entry_t decode_word(input logic [VEC_WORD_WIDTH-1:0] w);
        entry_t e;
        e.eol  = w[EOL_BIT];
        e.pos  = w[POS_BIT];
        e.line = w[LINE_BIT];
        e.x    = w[X_LSB +: VEC_OUT_WIDTH];
        e.y    = w[Y_LSB +: VEC_OUT_WIDTH];
        return e;
    endfunction

endpackage

// File: rtl/vector_list_fetch.sv
// ---------------------------------------------------------------------------
// vector_list_fetch
// Address side of the display-list walk: holds the frame base and the read
// pointer, issues memory reads, flags when the next address would wrap back
// to the base, and decodes the word coming back from memory.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start_i      : latch base_i as base and pointer, read the first word
//   base_i       : list base address
//   advance_i    : step pointer by one and read that word
//   rd_data_i    : memory read data (valid one cycle after rd_en_o)
//   rd_en_o      : registered read strobe
//   rd_addr_o    : read address (the current pointer)
//   wrap_o       : pointer+1 equals the latched base
//   entry_o      : decode of rd_data_i
// ---------------------------------------------------------------------------
module vector_list_fetch
    import vector_pkg::*;
#(
    parameter int ADDR_WIDTH = VEC_ADDR_WIDTH,
    parameter int WORD_WIDTH = VEC_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic                  advance_i,
    input  logic [WORD_WIDTH-1:0] rd_data_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  wrap_o,
    output entry_t                entry_o
);

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;
    logic [ADDR_WIDTH-1:0] ptr_inc;
    logic                  rd_en_q;
    logic                  rd_en_d;

    // Next pointer and read strobe; the pointer and the strobe move on the
    // same edge so rd_addr always names the word being read.
    always_comb begin
        ptr_inc = ptr_q + ADDR_WIDTH'(1);
        ptr_d   = ptr_q;
        rd_en_d = 1'b0;
        if (start_i) begin
            ptr_d   = base_i;
            rd_en_d = 1'b1;
        end else if (advance_i) begin
            ptr_d   = ptr_inc;
            rd_en_d = 1'b1;
        end
    end

    // The base is captured only at frame start so a list_base change
    // mid-frame takes effect on the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q  <= '0;
            ptr_q   <= '0;
            rd_en_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            rd_en_q <= rd_en_d;
            if (start_i) begin
                base_q <= base_i;
            end
        end
    end

    assign rd_en_o   = rd_en_q;
    assign rd_addr_o = ptr_q;
    assign wrap_o    = (ptr_inc == base_q);
    assign entry_o   = decode_word(rd_data_i);

endmodule

// File: rtl/vector_list_sequencer.sv
// ---------------------------------------------------------------------------
// vector_list_sequencer
// Frame-level controller for the vector display path. On a refresh strobe it
// walks a display list in synchronous memory, presenting one entry at a time
// to draw_vector_master and advancing on each inc edge. At end-of-list it
// waits for the line engine to go idle, pulses frame_done and parks until the
// next strobe.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   enable            : allows new frames to start
//   frame_tick        : one-cycle refresh strobe
//   list_base         : list start address, latched at frame start
//   rd_en/rd_addr     : memory read request
//   rd_data           : memory data, one cycle after rd_en
//   inc, busy         : request-next and busy from draw_vector_master
//   pos/line/o_x/o_y  : presented entry
//   drawing           : frame in progress
//   frame_done        : one-cycle end-of-frame pulse
//   overrun           : sticky, strobe arrived while drawing
//   list_err          : sticky, list wrapped without an eol word
// Optional feature macro: VEC_PARK_RETURN_EN presents a synthetic move to the
// origin after eol before finishing the frame.
// ---------------------------------------------------------------------------
module vector_list_sequencer
    import vector_pkg::*;
#(
    parameter int OUT_WIDTH  = VEC_OUT_WIDTH,
    parameter int ADDR_WIDTH = VEC_ADDR_WIDTH,
    parameter int WORD_WIDTH = 2 * OUT_WIDTH + 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  frame_tick,
    input  logic [ADDR_WIDTH-1:0] list_base,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [WORD_WIDTH-1:0] rd_data,
    input  logic                  inc,
    input  logic                  busy,
    output logic                  pos,
    output logic                  line,
    output logic [OUT_WIDTH-1:0]  o_x,
    output logic [OUT_WIDTH-1:0]  o_y,
    output logic                  drawing,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  list_err
);

    state_t               state_q;
    logic                 inc_q;
    logic                 drawing_q;
    logic                 frame_done_q;
    logic                 overrun_q;
    logic                 list_err_q;
    logic                 pos_q;
    logic                 line_q;
    logic [OUT_WIDTH-1:0] x_q;
    logic [OUT_WIDTH-1:0] y_q;

    logic   consume;
    logic   start;
    logic   advance;
    logic   wrap;
    entry_t entry;

    // drawing_q is still high in the frame_done cycle, so a strobe there is
    // an overrun rather than a start.
    assign consume = inc & ~inc_q & ~busy;
    assign start   = (state_q == HOLD) & frame_tick & enable & ~drawing_q;
    assign advance = (state_q == PRESENT) & consume & ~wrap;

    vector_list_fetch #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_fetch (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .base_i    (list_base),
        .advance_i (advance),
        .rd_data_i (rd_data),
        .rd_en_o   (rd_en),
        .rd_addr_o (rd_addr),
        .wrap_o    (wrap),
        .entry_o   (entry)
    );

    // Sequencer FSM with registered outputs. In LOAD an eol word is never
    // presented; with busy already low the frame finishes straight from LOAD
    // so an empty list completes three cycles after the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HOLD;
            inc_q        <= 1'b0;
            drawing_q    <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            list_err_q   <= 1'b0;
            pos_q        <= 1'b0;
            line_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            inc_q        <= inc;
            frame_done_q <= 1'b0;
            if (frame_tick && drawing_q) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                HOLD: begin
                    if (frame_done_q) begin
                        drawing_q <= 1'b0;
                    end
                    if (start) begin
                        drawing_q <= 1'b1;
                        state_q   <= RD;
                    end
                end
                RD: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    if (entry.eol) begin
`ifdef VEC_PARK_RETURN_EN
                        pos_q   <= 1'b1;
                        line_q  <= 1'b0;
                        x_q     <= '0;
                        y_q     <= '0;
                        state_q <= PARK;
`else
                        if (!busy) begin
                            frame_done_q <= 1'b1;
                            pos_q        <= 1'b0;
                            line_q       <= 1'b0;
                            state_q      <= HOLD;
                        end else begin
                            state_q <= DRAIN;
                        end
`endif
                    end else begin
                        pos_q   <= entry.pos;
                        line_q  <= entry.line;
                        x_q     <= entry.x;
                        y_q     <= entry.y;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (consume) begin
                        if (wrap) begin
                            list_err_q <= 1'b1;
                            state_q    <= DRAIN;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
`ifdef VEC_PARK_RETURN_EN
                PARK: begin
                    if (consume) begin
                        state_q <= DRAIN;
                    end
                end
`endif
                DRAIN: begin
                    if (!busy) begin
                        frame_done_q <= 1'b1;
                        pos_q        <= 1'b0;
                        line_q       <= 1'b0;
                        state_q      <= HOLD;
                    end
                end
                default: begin
                    state_q <= HOLD;
                end
            endcase
        end
    end

    assign pos        = pos_q;
    assign line       = line_q;
    assign o_x        = x_q;
    assign o_y        = y_q;
    assign drawing    = drawing_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign list_err   = list_err_q;

endmodule

// File: tb/tb_vector_list_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vector_list_sequencer
// Directed bench for vector_list_sequencer: a synchronous memory model holds
// the display lists and the bench plays the part of draw_vector_master.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_vector_list_sequencer;

    localparam int OW = 8;
    localparam int AW = 8;
    localparam int WW = 2 * OW + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          frame_tick = 1'b0;
    logic [AW-1:0] list_base = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [WW-1:0] rd_data = '0;
    logic          inc = 1'b0;
    logic          busy = 1'b0;
    logic          pos;
    logic          line;
    logic [OW-1:0] o_x;
    logic [OW-1:0] o_y;
    logic          drawing;
    logic          frame_done;
    logic          overrun;
    logic          list_err;

    logic [WW-1:0] mem [256];

    int compared = 0;
    int mismatched = 0;

    vector_list_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .frame_tick (frame_tick),
        .list_base  (list_base),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .inc        (inc),
        .busy       (busy),
        .pos        (pos),
        .line       (line),
        .o_x        (o_x),
        .o_y        (o_y),
        .drawing    (drawing),
        .frame_done (frame_done),
        .overrun    (overrun),
        .list_err   (list_err)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Synchronous display-list memory, one cycle read latency
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [WW-1:0] mkWord(input logic eol, input logic p, input logic l,
                                             input logic [OW-1:0] x, input logic [OW-1:0] y);
        return {eol, p, l, x, y};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkEntry(input string tag, input logic p, input logic l,
                              input logic [OW-1:0] x, input logic [OW-1:0] y);
        checkOutput(tag, 32'({pos, line, o_x, o_y}), 32'({p, l, x, y}));
    endtask

    task automatic applyStimulus_reset();
        rst = 1'b1;
        inc = 1'b0;
        busy = 1'b0;
        frame_tick = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Raises frame_tick for one cycle; returns one cycle after the strobe
    task automatic applyStimulus_tick(input logic [AW-1:0] base);
        list_base = base;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // Master model: one inc pulse, then busy while drawing. Returns three
    // cycles after inc rose, with busy still high.
    task automatic applyStimulus_inc();
        inc = 1'b1;
        busy = 1'b0;
        @(negedge clk);
        inc = 1'b0;
        busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic waitFrameDone(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = mkWord(1'b0, 1'b0, 1'b1, 8'd174, 8'd162);
        mem[8'h11] = mkWord(1'b0, 1'b0, 1'b1, 8'd161, 8'd147);
        mem[8'h12] = mkWord(1'b0, 1'b1, 1'b0, 8'd92,  8'd148);
        mem[8'h13] = mkWord(1'b1, 1'b0, 1'b0, 8'd0,   8'd0);
        mem[8'h40] = mkWord(1'b0, 1'b1, 1'b0, 8'd5,   8'd6);
        mem[8'h41] = mkWord(1'b1, 1'b0, 1'b0, 8'd0,   8'd0);
        mem[8'h80] = mkWord(1'b1, 1'b0, 1'b0, 8'd0,   8'd0);

        // ---------------- reset state ----------------
        @(negedge clk);
        checkOutput("reset outputs", 32'({rd_en, pos, line, o_x, o_y, drawing, frame_done, overrun, list_err}), 32'd0);
        applyStimulus_reset();
        checkOutput("reset rd_addr", 32'(rd_addr), 32'd0);

        // ---------------- empty list ----------------
        applyStimulus_tick(8'h80);
        checkOutput("empty drawing", 32'(drawing), 32'd1);
        checkOutput("empty pos/line c1", 32'({pos, line}), 32'd0);
        @(negedge clk);
        checkOutput("empty pos/line c2", 32'({pos, line}), 32'd0);
        @(negedge clk);
`ifdef VEC_PARK_RETURN_EN
        checkEntry("empty park entry", 1'b1, 1'b0, 8'd0, 8'd0);
        applyStimulus_inc();
        @(negedge clk);
        busy = 1'b0;
        waitFrameDone("empty frame_done", 10);
`else
        checkOutput("empty frame_done latency", 32'(frame_done), 32'd1);
        checkOutput("empty pos/line c3", 32'({pos, line}), 32'd0);
`endif
        // Strobe in the frame_done cycle counts as overrun, not a start
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        checkOutput("tick at frame_done overrun", 32'(overrun), 32'd1);
        checkOutput("tick at frame_done no start", 32'({drawing, rd_en}), 32'd0);

        // ---------------- main frame from 0x10 ----------------
        applyStimulus_reset();
        checkOutput("overrun cleared", 32'(overrun), 32'd0);
        applyStimulus_tick(8'h10);
        checkOutput("f1 drawing", 32'(drawing), 32'd1);
        checkOutput("f1 rd_en", 32'(rd_en), 32'd1);
        checkOutput("f1 rd_addr", 32'(rd_addr), 32'h10);
        @(negedge clk);
        checkOutput("f1 not yet presented", 32'({pos, line}), 32'd0);
        @(negedge clk);
        checkEntry("f1 entry0", 1'b0, 1'b1, 8'd174, 8'd162);

        // Base change and a stray strobe while drawing
        list_base = 8'h40;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        checkOutput("f1 overrun", 32'(overrun), 32'd1);
        checkOutput("f1 overrun no reread", 32'(rd_en), 32'd0);
        checkEntry("f1 entry0 held", 1'b0, 1'b1, 8'd174, 8'd162);

        // inc held high for 20 cycles: exactly one advance
        inc = 1'b1;
        busy = 1'b0;
        repeat (3) @(negedge clk);
        checkEntry("f1 entry1", 1'b0, 1'b1, 8'd161, 8'd147);
        repeat (17) @(negedge clk);
        checkEntry("f1 entry1 after held inc", 1'b0, 1'b1, 8'd161, 8'd147);
        checkOutput("f1 ptr after held inc", 32'(rd_addr), 32'h11);
        inc = 1'b0;
        @(negedge clk);

        applyStimulus_inc();
        checkEntry("f1 entry2", 1'b1, 1'b0, 8'd92, 8'd148);
        @(negedge clk);
        busy = 1'b0;
        @(negedge clk);

        applyStimulus_inc();
`ifdef VEC_PARK_RETURN_EN
        checkEntry("f1 park entry", 1'b1, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        busy = 1'b0;
        @(negedge clk);
        applyStimulus_inc();
`endif
        checkOutput("f1 draining", 32'({drawing, frame_done}), 32'b10);
        @(negedge clk);
        busy = 1'b0;
        checkOutput("f1 done waits busy", 32'(frame_done), 32'd0);
        @(negedge clk);
        checkOutput("f1 frame_done", 32'(frame_done), 32'd1);
        checkOutput("f1 drawing at done", 32'(drawing), 32'd1);
`ifdef VEC_PARK_RETURN_EN
        checkEntry("f1 end outputs", 1'b0, 1'b0, 8'd0, 8'd0);
`else
        checkEntry("f1 end outputs", 1'b0, 1'b0, 8'd92, 8'd148);
`endif
        @(negedge clk);
        checkOutput("f1 after done", 32'({drawing, frame_done}), 32'd0);

        // ---------------- second frame reads new base 0x40 ----------------
        applyStimulus_tick(8'h40);
        checkOutput("f2 rd_addr", 32'(rd_addr), 32'h40);
        @(negedge clk);
        @(negedge clk);
        checkEntry("f2 entry0", 1'b1, 1'b0, 8'd5, 8'd6);

        // ---------------- async reset during PRESENT ----------------
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst outputs", 32'({rd_en, pos, line, o_x, o_y, drawing, overrun}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus_tick(8'h10);
        checkOutput("post-rst rd_addr", 32'(rd_addr), 32'h10);
        @(negedge clk);
        @(negedge clk);
        checkEntry("post-rst entry0", 1'b0, 1'b1, 8'd174, 8'd162);

        // ---------------- 256 words, no eol ----------------
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            mem[i] = mkWord(1'b0, 1'b0, 1'b1, v, ~v);
        end
        applyStimulus_reset();
        applyStimulus_tick(8'h00);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            if ((i % 64) == 0 || i == 255) begin
                checkEntry($sformatf("sweep entry %0d", i), 1'b0, 1'b1, v, ~v);
            end
            inc = 1'b1;
            @(negedge clk);
            inc = 1'b0;
            if (i < 255) begin
                @(negedge clk);
                @(negedge clk);
            end
        end
        checkOutput("sweep list_err", 32'(list_err), 32'd1);
        waitFrameDone("sweep frame_done", 8);
        checkOutput("sweep no extra read", 32'(rd_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
